// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Optional WB_BYPASS_EN adds a write-to-read forwarding path in the top.
package regfile_wb_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

  function automatic wb_src_e other_src(input wb_src_e s);
    return (s == SRC_ALU) ? SRC_MEM : SRC_ALU;
  endfunction

  // Register 0 is hardwired, so it never gets a scoreboard bit.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] r);
    logic [NUM_REGS-1:0] v;
    v = '0;
    if (r != '0) v[r] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_writeback_arbiter_if.sv
// Bus bundle between the execute/memory producers, issue logic and the writeback arbiter.
// The WB_BYPASS_EN macro adds the forwarding read ports.
interface regfile_writeback_arbiter_if #(
  parameter int FIFO_DEPTH = 4
);
  import regfile_wb_pkg::*;

  // Producers: a request transfers on a clock edge where valid & ready are both high;
  // while valid is high and ready is low the producer holds rd/data stable.
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;

  logic [NUM_REGS-1:0] pending_mask;
  logic                reg_write;
  logic [ADDR_W-1:0]   write_reg;
  logic [DATA_W-1:0]   write_data;

  logic [$clog2(FIFO_DEPTH):0] dbg_alu_count;
  logic [$clog2(FIFO_DEPTH):0] dbg_mem_count;
  wb_src_e                     dbg_prio;

`ifdef WB_BYPASS_EN
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [DATA_W-1:0] rf_data1;
  logic [DATA_W-1:0] rf_data2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
`endif

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output issue_valid, issue_rd,
    input  alu_ready, mem_ready, pending_mask, reg_write, write_reg, write_data,
    input  dbg_alu_count, dbg_mem_count, dbg_prio
`ifdef WB_BYPASS_EN
    , output read_reg1, read_reg2, rf_data1, rf_data2
    , input  read_data1, read_data2
`endif
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  issue_valid, issue_rd,
    output alu_ready, mem_ready, pending_mask, reg_write, write_reg, write_data,
    output dbg_alu_count, dbg_mem_count, dbg_prio
`ifdef WB_BYPASS_EN
    , input  read_reg1, read_reg2, rf_data1, rf_data2
    , output read_data1, read_data2
`endif
  );

endinterface

// File: rtl/regfile_writeback_arbiter_wb_fifo.sv
// Synchronous FIFO of writeback requests; wrapping pointers plus an occupancy count.
// Push on full and pop on empty are ignored.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        i_push,
  input  wb_req_t                     i_push_data,
  input  logic                        i_pop,
  output wb_req_t                     o_pop_data,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(FIFO_DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

  wb_req_t          r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_full     = (r_count == FULL_CNT);
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage needs no reset: entries are only visible through the count.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Writeback front end: per-producer FIFOs, round-robin arbiter, registered write port,
// pending-write scoreboard. Define WB_BYPASS_EN for write-to-read forwarding.
module regfile_writeback_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  regfile_writeback_arbiter_if.slave  wb_bus
);

  logic                        w_alu_full, w_alu_empty, w_alu_push, w_alu_pop;
  logic                        w_mem_full, w_mem_empty, w_mem_push, w_mem_pop;
  logic [$clog2(FIFO_DEPTH):0] w_alu_count, w_mem_count;
  wb_req_t                     w_alu_head, w_mem_head, w_alu_in, w_mem_in, w_head;

  logic                        w_any;
  logic                        w_two_way;
  wb_src_e                     w_grant;
  wb_src_e                     r_prio;

  logic                        r_reg_write;
  logic [ADDR_W-1:0]           r_write_reg;
  logic [DATA_W-1:0]           r_write_data;

  logic [NUM_REGS-1:0]         r_pending;
  logic [NUM_REGS-1:0]         w_set;
  logic [NUM_REGS-1:0]         w_clr;

  // Writes to x0 complete the handshake but are dropped before the FIFO.
  assign w_alu_push = wb_bus.alu_valid & ~w_alu_full & (wb_bus.alu_rd != '0);
  assign w_mem_push = wb_bus.mem_valid & ~w_mem_full & (wb_bus.mem_rd != '0);
  assign w_alu_in   = '{rd: wb_bus.alu_rd, data: wb_bus.alu_data};
  assign w_mem_in   = '{rd: wb_bus.mem_rd, data: wb_bus.mem_data};

  wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_alu_push),
    .i_push_data (w_alu_in),
    .i_pop       (w_alu_pop),
    .o_pop_data  (w_alu_head),
    .o_full      (w_alu_full),
    .o_empty     (w_alu_empty),
    .o_count     (w_alu_count)
  );

  wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_mem_push),
    .i_push_data (w_mem_in),
    .i_pop       (w_mem_pop),
    .o_pop_data  (w_mem_head),
    .o_full      (w_mem_full),
    .o_empty     (w_mem_empty),
    .o_count     (w_mem_count)
  );

  always_comb begin
    w_two_way = 1'b0;
    w_grant   = SRC_ALU;
    w_any     = ~w_alu_empty | ~w_mem_empty;
    if (~w_alu_empty && ~w_mem_empty) begin
      w_two_way = 1'b1;
      w_grant   = r_prio;
    end else if (~w_mem_empty) begin
      w_grant   = SRC_MEM;
    end
    w_alu_pop = w_any & (w_grant == SRC_ALU);
    w_mem_pop = w_any & (w_grant == SRC_MEM);
    w_head    = (w_grant == SRC_MEM) ? w_mem_head : w_alu_head;
  end

  // Priority only moves on contested cycles, so a lone producer never loses its turn.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          r_prio <= SRC_ALU;
    else if (w_two_way) r_prio <= other_src(w_grant);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else if (w_any) begin
      r_reg_write  <= 1'b1;
      r_write_reg  <= w_head.rd;
      r_write_data <= w_head.data;
    end else begin
      r_reg_write  <= 1'b0;
    end
  end

  assign w_set = wb_bus.issue_valid ? reg_onehot(wb_bus.issue_rd) : '0;
  assign w_clr = r_reg_write ? reg_onehot(r_write_reg) : '0;

  // Set is applied after clear so a re-issue in the commit cycle keeps the bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_pending <= '0;
    else       r_pending <= (r_pending & ~w_clr) | w_set;
  end

  assign wb_bus.alu_ready     = ~w_alu_full;
  assign wb_bus.mem_ready     = ~w_mem_full;
  assign wb_bus.pending_mask  = r_pending;
  assign wb_bus.reg_write     = r_reg_write;
  assign wb_bus.write_reg     = r_write_reg;
  assign wb_bus.write_data    = r_write_data;
  assign wb_bus.dbg_alu_count = w_alu_count;
  assign wb_bus.dbg_mem_count = w_mem_count;
  assign wb_bus.dbg_prio      = r_prio;

`ifdef WB_BYPASS_EN
  assign wb_bus.read_data1 = (r_reg_write && (r_write_reg == wb_bus.read_reg1) && (wb_bus.read_reg1 != '0))
                             ? r_write_data : wb_bus.rf_data1;
  assign wb_bus.read_data2 = (r_reg_write && (r_write_reg == wb_bus.read_reg2) && (wb_bus.read_reg2 != '0))
                             ? r_write_data : wb_bus.rf_data2;
`endif

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Bench for regfile_writeback_arbiter: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_writeback_arbiter;
  import regfile_wb_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  regfile_writeback_arbiter_if #(.FIFO_DEPTH(DEPTH)) wb_bus ();

  regfile_writeback_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clock  (clock),
    .reset  (reset),
    .wb_bus (wb_bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic chk_en    = 1'b0;
  logic rand_rd_en = 1'b0;

  wb_req_t alu_src_q[$];
  wb_req_t mem_src_q[$];

  // ---------------- reference model ----------------
  wb_req_t     m_alu_q[$];
  wb_req_t     m_mem_q[$];
  logic        m_prio_mem;
  logic        exp_rw;
  logic [4:0]  exp_wr;
  logic [31:0] exp_wd;
  logic [31:0] m_pending;
  logic        m_alu_acc, m_mem_acc;

  function automatic wb_req_t mk(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
    wb_req_t r;
    r.rd   = rd;
    r.data = data;
    return r;
  endfunction

  task automatic model_step();
    int a_n, m_n;
    logic pre_rw;
    logic [4:0] pre_wr;
    wb_req_t e;
    logic [31:0] clr_v, set_v;
    if (reset) begin
      m_alu_q.delete();
      m_mem_q.delete();
      m_prio_mem = 1'b0;
      exp_rw = 1'b0; exp_wr = '0; exp_wd = '0;
      m_pending = '0;
      m_alu_acc = 1'b0; m_mem_acc = 1'b0;
      return;
    end
    a_n = m_alu_q.size();
    m_n = m_mem_q.size();
    pre_rw = exp_rw;
    pre_wr = exp_wr;
    e = '0;
    exp_rw = 1'b1;
    if (a_n > 0 && m_n > 0) begin
      if (!m_prio_mem) e = m_alu_q.pop_front();
      else             e = m_mem_q.pop_front();
      m_prio_mem = !m_prio_mem;
    end else if (a_n > 0) e = m_alu_q.pop_front();
    else if (m_n > 0)     e = m_mem_q.pop_front();
    else                  exp_rw = 1'b0;
    if (exp_rw) begin exp_wr = e.rd; exp_wd = e.data; end
    clr_v = pre_rw ? (32'd1 << pre_wr) : 32'd0;
    set_v = (wb_bus.issue_valid && wb_bus.issue_rd != 0) ? (32'd1 << wb_bus.issue_rd) : 32'd0;
    m_pending = ((m_pending & ~clr_v) | set_v) & 32'hFFFF_FFFE;
    m_alu_acc = wb_bus.alu_valid && (a_n < DEPTH);
    m_mem_acc = wb_bus.mem_valid && (m_n < DEPTH);
    if (m_alu_acc && wb_bus.alu_rd != 0) m_alu_q.push_back(mk(wb_bus.alu_rd, wb_bus.alu_data));
    if (m_mem_acc && wb_bus.mem_rd != 0) m_mem_q.push_back(mk(wb_bus.mem_rd, wb_bus.mem_data));
  endtask

  initial forever begin
    @(posedge clock or posedge reset);
    model_step();
  end

  // ---------------- scoreboard compare ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      check("alu_ready",    wb_bus.alu_ready,    m_alu_q.size() < DEPTH);
      check("mem_ready",    wb_bus.mem_ready,    m_mem_q.size() < DEPTH);
      check("reg_write",    wb_bus.reg_write,    exp_rw);
      check("write_reg",    wb_bus.write_reg,    exp_wr);
      check("write_data",   wb_bus.write_data,   exp_wd);
      check("pending_mask", wb_bus.pending_mask, m_pending);
      check("alu_count",    wb_bus.dbg_alu_count, m_alu_q.size());
      check("mem_count",    wb_bus.dbg_mem_count, m_mem_q.size());
`ifdef WB_BYPASS_EN
      check("read_data1", wb_bus.read_data1,
            (exp_rw && exp_wr == wb_bus.read_reg1 && wb_bus.read_reg1 != 0) ? exp_wd : wb_bus.rf_data1);
      check("read_data2", wb_bus.read_data2,
            (exp_rw && exp_wr == wb_bus.read_reg2 && wb_bus.read_reg2 != 0) ? exp_wd : wb_bus.rf_data2);
`endif
    end
  end

  // ---------------- producer driver ----------------
  initial begin
    wb_req_t r;
    wb_bus.alu_valid = 1'b0; wb_bus.alu_rd = '0; wb_bus.alu_data = '0;
    wb_bus.mem_valid = 1'b0; wb_bus.mem_rd = '0; wb_bus.mem_data = '0;
`ifdef WB_BYPASS_EN
    wb_bus.read_reg1 = '0; wb_bus.read_reg2 = '0; wb_bus.rf_data1 = '0; wb_bus.rf_data2 = '0;
`endif
    forever begin
      @(posedge clock);
      #2;
      if (reset) begin
        wb_bus.alu_valid = 1'b0;
        wb_bus.mem_valid = 1'b0;
      end else begin
        if (!wb_bus.alu_valid || m_alu_acc) begin
          if (alu_src_q.size() > 0) begin
            r = alu_src_q.pop_front();
            wb_bus.alu_valid = 1'b1; wb_bus.alu_rd = r.rd; wb_bus.alu_data = r.data;
          end else wb_bus.alu_valid = 1'b0;
        end
        if (!wb_bus.mem_valid || m_mem_acc) begin
          if (mem_src_q.size() > 0) begin
            r = mem_src_q.pop_front();
            wb_bus.mem_valid = 1'b1; wb_bus.mem_rd = r.rd; wb_bus.mem_data = r.data;
          end else wb_bus.mem_valid = 1'b0;
        end
`ifdef WB_BYPASS_EN
        if (rand_rd_en) begin
          wb_bus.read_reg1 = ADDR_W'($urandom_range(0, 31));
          wb_bus.read_reg2 = ADDR_W'($urandom_range(0, 31));
          wb_bus.rf_data1  = $urandom();
          wb_bus.rf_data2  = $urandom();
        end
`endif
      end
    end
  end

  task automatic wait_idle(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clock);
      if (alu_src_q.size() == 0 && mem_src_q.size() == 0 && m_alu_q.size() == 0 &&
          m_mem_q.size() == 0 && !exp_rw && !wb_bus.alu_valid && !wb_bus.mem_valid)
        done = 1'b1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: not idle after %0d cycles", name, budget);
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int writes;
    logic seen_low;
    wb_bus.issue_valid = 1'b0;
    wb_bus.issue_rd    = '0;
    repeat (2) @(negedge clock);
    check("rst_reg_write",  wb_bus.reg_write,    0);
    check("rst_write_reg",  wb_bus.write_reg,    0);
    check("rst_write_data", wb_bus.write_data,   0);
    check("rst_pending",    wb_bus.pending_mask, 0);
    check("rst_alu_ready",  wb_bus.alu_ready,    1);
    check("rst_mem_ready",  wb_bus.mem_ready,    1);
    chk_en = 1'b1;
    reset  = 1'b0;
    repeat (2) @(negedge clock);

    // single ALU write: visible the cycle after acceptance, for one cycle
    alu_src_q.push_back(mk(5'd3, 32'hDEADBEEF));
    repeat (2) @(negedge clock);
    check("t1_rw_accept_cycle", wb_bus.reg_write, 0);
    @(negedge clock);
    check("t1_rw",  wb_bus.reg_write,  1);
    check("t1_reg", wb_bus.write_reg,  3);
    check("t1_dat", wb_bus.write_data, 32'hDEADBEEF);
    @(negedge clock);
    check("t1_rw_drop",  wb_bus.reg_write, 0);
    check("t1_reg_hold", wb_bus.write_reg, 3);
    wait_idle("t1", 20);

    // both producers streaming: alternate starting with ALU, nothing lost
    for (int i = 0; i < 8; i++) begin
      alu_src_q.push_back(mk(ADDR_W'(10 + i), 32'hA000_0000 + i));
      mem_src_q.push_back(mk(ADDR_W'(20 + i), 32'hB000_0000 + i));
    end
    writes = 0;
    seen_low = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (wb_bus.reg_write) writes++;
      if (!wb_bus.mem_ready) seen_low = 1'b1;
      if (k == 3) check("t2_first_alu",  wb_bus.write_reg, 10);
      if (k == 4) check("t2_second_mem", wb_bus.write_reg, 20);
      if (k == 5) check("t2_third_alu",  wb_bus.write_reg, 11);
    end
    check("t2_write_count",    writes,   16);
    check("t2_mem_ready_drop", seen_low, 1);
    wait_idle("t2", 20);

    // scoreboard set, issue to x0 ignored, cleared the edge after the write
    wb_bus.issue_valid = 1'b1; wb_bus.issue_rd = 5'd7;
    @(negedge clock);
    wb_bus.issue_rd = 5'd0;
    check("t4_set7", wb_bus.pending_mask, 32'h0000_0080);
    @(negedge clock);
    wb_bus.issue_valid = 1'b0;
    check("t4_rd0_nochange", wb_bus.pending_mask, 32'h0000_0080);
    alu_src_q.push_back(mk(5'd7, 32'h0000_7777));
    repeat (2) @(negedge clock);
    check("t4_still_pending", wb_bus.pending_mask, 32'h0000_0080);
    @(negedge clock);
    check("t4_rw7", wb_bus.write_reg, 7);
    check("t4_pending_during_write", wb_bus.pending_mask, 32'h0000_0080);
    @(negedge clock);
    check("t4_cleared", wb_bus.pending_mask, 32'h0);
    wait_idle("t4", 20);

    // set wins over clear on the same bit
    wb_bus.issue_valid = 1'b1; wb_bus.issue_rd = 5'd5;
    @(negedge clock);
    wb_bus.issue_valid = 1'b0;
    check("t5_set5", wb_bus.pending_mask, 32'h0000_0020);
    alu_src_q.push_back(mk(5'd5, 32'h0000_5555));
    repeat (3) @(negedge clock);
    check("t5_rw5", wb_bus.write_reg, 5);
    wb_bus.issue_valid = 1'b1; wb_bus.issue_rd = 5'd5;
    @(negedge clock);
    wb_bus.issue_valid = 1'b0;
    check("t5_set_wins", wb_bus.pending_mask, 32'h0000_0020);
    wait_idle("t5a", 20);
    alu_src_q.push_back(mk(5'd5, 32'h0000_5556));
    wait_idle("t5b", 20);
    check("t5_cleared", wb_bus.pending_mask, 32'h0);

`ifdef WB_BYPASS_EN
    wb_bus.read_reg1 = 5'd9; wb_bus.rf_data1 = 32'hCAFE_0000;
    alu_src_q.push_back(mk(5'd9, 32'h0000_1234));
    repeat (3) @(negedge clock);
    check("byp_forward", wb_bus.read_data1, 32'h0000_1234);
    @(negedge clock);
    check("byp_regfile", wb_bus.read_data1, 32'hCAFE_0000);
    wait_idle("byp", 20);
`endif

    // asynchronous reset with writes queued
    wb_bus.issue_valid = 1'b1; wb_bus.issue_rd = 5'd9;
    @(negedge clock);
    wb_bus.issue_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      alu_src_q.push_back(mk(ADDR_W'(1 + i), 32'h1100_0000 + i));
      mem_src_q.push_back(mk(ADDR_W'(16 + i), 32'h2200_0000 + i));
    end
    repeat (5) @(negedge clock);
    @(posedge clock);
    #3;
    check("t6_rw_before_reset", wb_bus.reg_write, 1);
    reset = 1'b1;
    alu_src_q.delete();
    mem_src_q.delete();
    #1;
    check("t6_rw_async_drop", wb_bus.reg_write, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("t6_pending_zero", wb_bus.pending_mask, 32'h0);
    check("t6_alu_empty",    wb_bus.dbg_alu_count, 0);
    check("t6_mem_empty",    wb_bus.dbg_mem_count, 0);
    check("t6_rw_zero",      wb_bus.reg_write, 0);
    repeat (3) @(negedge clock);
    check("t6_no_stale_write", wb_bus.reg_write, 0);

    // randomized traffic at three load levels
    rand_rd_en = 1'b1;
    for (int p = 0; p < 3; p++) begin
      int prob;
      prob = (p == 0) ? 30 : (p == 1) ? 60 : 95;
      repeat (600) begin
        int r;
        @(negedge clock);
        if (alu_src_q.size() < 2 && $urandom_range(0, 99) < prob)
          alu_src_q.push_back(mk(ADDR_W'($urandom_range(0, 31)), $urandom()));
        if (mem_src_q.size() < 2 && $urandom_range(0, 99) < prob)
          mem_src_q.push_back(mk(ADDR_W'($urandom_range(0, 31)), $urandom()));
        r = $urandom_range(0, 31);
        if ($urandom_range(0, 99) < 30 && !m_pending[r]) begin
          wb_bus.issue_valid = 1'b1;
          wb_bus.issue_rd    = ADDR_W'(r);
        end else begin
          wb_bus.issue_valid = 1'b0;
        end
      end
    end
    wb_bus.issue_valid = 1'b0;
    wait_idle("random", 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
